// File: rtl/ball_physics_controller_if.sv
// rtl/ball_physics_controller_if.sv - frame, collision and ball-state bundle between game top and ball controller
interface ball_physics_controller_if #(
  parameter int SPEED_W = 16
);
  logic                      startOfFrame;
  logic                      pause;
  logic                      resetLevel;
  logic [3:0]                level;
  logic                      launch;
  logic                      collisionBorderTop;
  logic                      collisionBorderLeft;
  logic                      collisionBorderRight;
  logic                      collisionFlipper;
  logic                      collisionObstacle;
  logic [3:0]                hitEdgeCode;
  logic signed [SPEED_W-1:0] flipperSpeedX;
  logic signed [10:0]        topLeftX;
  logic signed [10:0]        topLeftY;
  logic signed [SPEED_W-1:0] speedX;
  logic signed [SPEED_W-1:0] speedY;
  logic [1:0]                state;
  logic                      obstacleHit;
  logic                      ballLost;

  modport master (
    output startOfFrame, pause, resetLevel, level, launch,
           collisionBorderTop, collisionBorderLeft, collisionBorderRight,
           collisionFlipper, collisionObstacle, hitEdgeCode, flipperSpeedX,
    input  topLeftX, topLeftY, speedX, speedY, state, obstacleHit, ballLost
  );

  modport slave (
    input  startOfFrame, pause, resetLevel, level, launch,
           collisionBorderTop, collisionBorderLeft, collisionBorderRight,
           collisionFlipper, collisionObstacle, hitEdgeCode, flipperSpeedX,
    output topLeftX, topLeftY, speedX, speedY, state, obstacleHit, ballLost
  );
endinterface

// File: rtl/ball_physics_controller.sv
// rtl/ball_physics_controller.sv - fixed-point ball integrator with gravity, saturation, reflections and serve/lost FSM
module ball_physics_controller #(
  parameter int FRAC_BITS    = 6,
  parameter int SPEED_W      = 16,
  parameter int GRAVITY      = 2,
  parameter int MAX_SPEED    = 512,
  parameter int INIT_X       = 300,
  parameter int INIT_Y       = 40,
  parameter int INIT_Y_SPEED = 64,
  parameter int LOST_Y       = 470
) (
  input  logic                     clk,
  input  logic                     reset,
  ball_physics_controller_if.slave bus
);
  localparam int POS_W = 12 + FRAC_BITS;
  localparam logic signed [SPEED_W:0]   MAX_POS    = (SPEED_W+1)'(MAX_SPEED);
  localparam logic signed [SPEED_W:0]   MAX_NEG    = (SPEED_W+1)'(-MAX_SPEED);
  localparam logic signed [SPEED_W:0]   GRAV       = (SPEED_W+1)'(GRAVITY);
  localparam logic signed [POS_W-1:0]   SERVE_X    = POS_W'(INIT_X * (1 << FRAC_BITS));
  localparam logic signed [POS_W-1:0]   SERVE_Y    = POS_W'(INIT_Y * (1 << FRAC_BITS));
  localparam logic signed [POS_W-1:0]   LOST_LIMIT = POS_W'(LOST_Y);

  typedef enum logic [1:0] {ARMED = 2'd0, FLIGHT = 2'd1, LOST = 2'd2} ballState_t;

  ballState_t                state;
  logic signed [POS_W-1:0]   posX, posY;
  logic signed [SPEED_W-1:0] speedX, speedY;
  logic                      xLatch, yLatch, frameObstacle;
  logic                      obstacleHit, ballLost;

  function automatic logic signed [SPEED_W-1:0] sat(input logic signed [SPEED_W:0] v);
    if (v > MAX_POS)      return MAX_POS[SPEED_W-1:0];
    else if (v < MAX_NEG) return MAX_NEG[SPEED_W-1:0];
    else                  return v[SPEED_W-1:0];
  endfunction

  logic signed [SPEED_W:0]   extX, extY, extFlip, extHeldY;
  logic signed [SPEED_W-1:0] heldSpeedY, nextSpeedX, gravSpeedY, launchSpeed;
  logic signed [POS_W-1:0]   nextPosX, nextPosY, nextIntY;
  logic                      yNeg, yPos, xNeg, xPos;
  logic                      yBorder, yObs, yHit, xBorder, xObs, xFlip, xMatch, obstacleEvent;
  int                        launchRaw;

  always_comb begin
    extX     = {speedX[SPEED_W-1], speedX};
    extY     = {speedY[SPEED_W-1], speedY};
    extFlip  = {bus.flipperSpeedX[SPEED_W-1], bus.flipperSpeedX};
    yNeg     = speedY[SPEED_W-1];
    yPos     = !speedY[SPEED_W-1] && (speedY != '0);
    xNeg     = speedX[SPEED_W-1];
    xPos     = !speedX[SPEED_W-1] && (speedX != '0);

    // Y axis: borders/flipper take precedence over obstacle edges
    yBorder  = (bus.collisionBorderTop && yNeg) || (bus.collisionFlipper && yPos);
    yObs     = bus.collisionObstacle && ((bus.hitEdgeCode[2] && yNeg) || (bus.hitEdgeCode[0] && yPos));
    yHit     = !yLatch && (yBorder || yObs);
    heldSpeedY = yHit ? sat(-extY) : speedY;

    // X axis: borders, then obstacle edges, then flipper kick
    xBorder  = (bus.collisionBorderLeft && xNeg) || (bus.collisionBorderRight && xPos);
    xObs     = bus.collisionObstacle && ((bus.hitEdgeCode[3] && xNeg) || (bus.hitEdgeCode[1] && xPos));
    xFlip    = bus.collisionFlipper && yPos;
    xMatch   = !xLatch && (xBorder || xObs || xFlip);
    nextSpeedX = speedX;
    if (!xLatch) begin
      if (xBorder || xObs) nextSpeedX = sat(-extX);
      else if (xFlip)      nextSpeedX = sat(extX + extFlip);
    end

    obstacleEvent = (!yLatch && !yBorder && yObs) || (!xLatch && !xBorder && xObs);

    extHeldY   = {heldSpeedY[SPEED_W-1], heldSpeedY};
    gravSpeedY = sat(extHeldY + GRAV);
    nextPosX   = posX + POS_W'(speedX);
    nextPosY   = posY + POS_W'(speedY);
    nextIntY   = nextPosY >>> FRAC_BITS;

    launchRaw = INIT_Y_SPEED * (int'(bus.level) + 1);
    if (launchRaw > MAX_SPEED)       launchSpeed = SPEED_W'(MAX_SPEED);
    else if (launchRaw < -MAX_SPEED) launchSpeed = SPEED_W'(-MAX_SPEED);
    else                             launchSpeed = SPEED_W'(launchRaw);
  end

  always_ff @(posedge clk) begin
    if (reset || bus.resetLevel) begin
      state         <= ARMED;
      posX          <= SERVE_X;
      posY          <= SERVE_Y;
      speedX        <= '0;
      speedY        <= '0;
      xLatch        <= 1'b0;
      yLatch        <= 1'b0;
      frameObstacle <= 1'b0;
      obstacleHit   <= 1'b0;
      ballLost      <= 1'b0;
    end else if (bus.pause) begin
      obstacleHit <= 1'b0;
      ballLost    <= 1'b0;
    end else begin
      obstacleHit <= 1'b0;
      ballLost    <= 1'b0;
      case (state)
        ARMED: begin
          posX          <= SERVE_X;
          posY          <= SERVE_Y;
          speedX        <= '0;
          speedY        <= '0;
          xLatch        <= 1'b0;
          yLatch        <= 1'b0;
          frameObstacle <= 1'b0;
          if (bus.launch) begin
            state  <= FLIGHT;
            speedY <= launchSpeed;
          end
        end
        FLIGHT: begin
          speedX <= nextSpeedX;
          speedY <= heldSpeedY;
          if (xMatch) xLatch <= 1'b1;
          if (yHit)   yLatch <= 1'b1;
          if (obstacleEvent && !frameObstacle) begin
            obstacleHit   <= 1'b1;
            frameObstacle <= 1'b1;
          end
          // Integration uses the speed held before this cycle's reflection
          if (bus.startOfFrame) begin
            posX          <= nextPosX;
            posY          <= nextPosY;
            speedY        <= gravSpeedY;
            xLatch        <= 1'b0;
            yLatch        <= 1'b0;
            frameObstacle <= 1'b0;
            if (nextIntY > LOST_LIMIT) begin
              state    <= LOST;
              ballLost <= 1'b1;
            end
          end
        end
        LOST: begin
          if (bus.launch) begin
            state  <= ARMED;
            posX   <= SERVE_X;
            posY   <= SERVE_Y;
            speedX <= '0;
            speedY <= '0;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  assign bus.topLeftX    = 11'(posX >>> FRAC_BITS);
  assign bus.topLeftY    = 11'(posY >>> FRAC_BITS);
  assign bus.speedX      = speedX;
  assign bus.speedY      = speedY;
  assign bus.state       = state;
  assign bus.obstacleHit = obstacleHit;
  assign bus.ballLost    = ballLost;
endmodule

// File: tb/tb_ball_physics_controller.sv
// tb/tb_ball_physics_controller.sv - directed bench for ball_physics_controller
module tb_ball_physics_controller;
  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   modelY, modelX, modelV, frozenY;
  bit   lostSeen;

  ball_physics_controller_if #(.SPEED_W(16)) bus ();

  ball_physics_controller dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input int got, input int exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.startOfFrame = 1'b1;
    step();
    bus.startOfFrame = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.startOfFrame = 0; bus.pause = 0; bus.resetLevel = 0; bus.level = 0; bus.launch = 0;
    bus.collisionBorderTop = 0; bus.collisionBorderLeft = 0; bus.collisionBorderRight = 0;
    bus.collisionFlipper = 0; bus.collisionObstacle = 0; bus.hitEdgeCode = 0; bus.flipperSpeedX = 0;
    step(); step();
    reset = 1'b0;
    checkValue("rstState", bus.state, 0);
    checkValue("rstX", bus.topLeftX, 300);
    checkValue("rstY", bus.topLeftY, 40);
    checkValue("rstSpeedX", bus.speedX, 0);
    checkValue("rstSpeedY", bus.speedY, 0);
    checkValue("rstObstacleHit", bus.obstacleHit, 0);
    checkValue("rstBallLost", bus.ballLost, 0);

    bus.level = 1; bus.launch = 1; step(); bus.launch = 0;
    checkValue("launchState", bus.state, 1);
    checkValue("launchSpeedY", bus.speedY, 128);
    checkValue("launchSpeedX", bus.speedX, 0);
    frame();
    checkValue("f1Y", bus.topLeftY, 42);
    checkValue("f1SpeedY", bus.speedY, 130);
    frame();
    checkValue("f2Y", bus.topLeftY, 44);
    checkValue("f2SpeedY", bus.speedY, 132);
    checkValue("f2X", bus.topLeftX, 300);

    bus.flipperSpeedX = 40; bus.collisionFlipper = 1; step(); bus.collisionFlipper = 0;
    checkValue("flipSpeedY", bus.speedY, -132);
    checkValue("flipSpeedX", bus.speedX, 40);
    frame();
    checkValue("f3Y", bus.topLeftY, 41);
    checkValue("f3SpeedY", bus.speedY, -130);

    bus.flipperSpeedX = 0;
    bus.collisionBorderTop = 1; step();
    checkValue("topFlip", bus.speedY, 130);
    bus.collisionFlipper = 1; step(); bus.collisionFlipper = 0;
    checkValue("topLatchY", bus.speedY, 130);
    checkValue("topLatchX", bus.speedX, 40);
    step(); bus.collisionBorderTop = 0;
    checkValue("topHeld", bus.speedY, 130);
    frame();
    checkValue("f4Y", bus.topLeftY, 44);
    checkValue("f4SpeedY", bus.speedY, 132);

    bus.collisionObstacle = 1; bus.hitEdgeCode = 4'b0001; step();
    checkValue("obsSpeedY", bus.speedY, -132);
    checkValue("obsPulse", bus.obstacleHit, 1);
    step(); bus.collisionObstacle = 0;
    checkValue("obsSpeedY2", bus.speedY, -132);
    checkValue("obsPulseEnd", bus.obstacleHit, 0);
    step();
    checkValue("obsPulseIdle", bus.obstacleHit, 0);
    frame();
    checkValue("f5Y", bus.topLeftY, 41);
    checkValue("f5SpeedY", bus.speedY, -130);
    checkValue("f5X", bus.topLeftX, 301);
    bus.collisionObstacle = 1; step();
    checkValue("obsNoFlip", bus.speedY, -130);
    checkValue("obsNoPulse", bus.obstacleHit, 0);
    step(); bus.collisionObstacle = 0; bus.hitEdgeCode = 0;
    checkValue("obsNoPulse2", bus.obstacleHit, 0);

    modelY = 2684; modelX = 19320; modelV = -130; lostSeen = 0;
    for (int i = 0; i < 400 && !lostSeen; i++) begin
      frame();
      modelY += modelV;
      modelX += 40;
      modelV = (modelV + 2 > 512) ? 512 : modelV + 2;
      if ((modelY >>> 6) > 470) begin
        lostSeen = 1;
        checkValue("lostPulse", bus.ballLost, 1);
        checkValue("lostState", bus.state, 2);
        checkValue("lostY", bus.topLeftY, modelY >>> 6);
        checkValue("lostX", bus.topLeftX, modelX >>> 6);
        checkValue("lostSpeedY", bus.speedY, modelV);
      end
    end
    if (!lostSeen) checkValue("lostTimeout", 0, 1);
    frozenY = modelY >>> 6;
    step();
    checkValue("lostPulseEnd", bus.ballLost, 0);
    for (int i = 0; i < 5; i++) frame();
    checkValue("frozenY", bus.topLeftY, frozenY);
    checkValue("frozenState", bus.state, 2);
    checkValue("frozenSpeedY", bus.speedY, modelV);
    checkValue("frozenNoPulse", bus.ballLost, 0);

    bus.launch = 1; step(); bus.launch = 0;
    checkValue("rearmState", bus.state, 0);
    checkValue("rearmX", bus.topLeftX, 300);
    checkValue("rearmY", bus.topLeftY, 40);
    checkValue("rearmSpeedY", bus.speedY, 0);
    bus.level = 7; bus.launch = 1; step(); bus.launch = 0;
    checkValue("serveState", bus.state, 1);
    checkValue("serveSpeedY", bus.speedY, 512);
    for (int i = 1; i <= 3; i++) begin
      frame();
      checkValue("satSpeedY", bus.speedY, 512);
      checkValue("satY", bus.topLeftY, 40 + 8 * i);
    end

    bus.flipperSpeedX = 600; bus.collisionFlipper = 1; step(); bus.collisionFlipper = 0;
    checkValue("kickSatX", bus.speedX, 512);
    checkValue("kickFlipY", bus.speedY, -512);

    bus.pause = 1; frame();
    checkValue("pauseY", bus.topLeftY, 64);
    checkValue("pauseSpeedY", bus.speedY, -512);
    bus.resetLevel = 1; step(); bus.resetLevel = 0;
    checkValue("rlState", bus.state, 0);
    checkValue("rlX", bus.topLeftX, 300);
    checkValue("rlY", bus.topLeftY, 40);
    checkValue("rlSpeedX", bus.speedX, 0);
    checkValue("rlSpeedY", bus.speedY, 0);
    bus.pause = 0;

    bus.level = 1; bus.launch = 1; bus.startOfFrame = 1; step();
    bus.launch = 0; bus.startOfFrame = 0;
    checkValue("sofLaunchState", bus.state, 1);
    checkValue("sofLaunchY", bus.topLeftY, 40);
    checkValue("sofLaunchSpeedY", bus.speedY, 128);
    frame();
    checkValue("sofNextY", bus.topLeftY, 42);
    reset = 1; step(); reset = 0;
    checkValue("midRstState", bus.state, 0);
    checkValue("midRstX", bus.topLeftX, 300);
    checkValue("midRstY", bus.topLeftY, 40);
    checkValue("midRstSpeedX", bus.speedX, 0);
    checkValue("midRstSpeedY", bus.speedY, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/ball_physics_controller.md
# ball_physics_controller

Parametrised successor of the single-ball smiley motion controller. It integrates one ball's fixed-point position once per video frame, applying gravity and speed saturation. It reflects the speed on border, flipper and obstacle collisions, at most once per axis per frame. A launch/lost state machine lets the game top level re-serve the ball without a level reset. It sits between the collision detectors and the ball drawing/score logic.

## Interface
Parameters:
- FRAC_BITS, 6: fractional bits of position/speed (1 unit = 2^-FRAC_BITS px)
- SPEED_W, 16: signed speed width
- GRAVITY, 2: signed speed units added to Y speed per frame in FLIGHT
- MAX_SPEED, 512: saturation magnitude; both speeds are held in [-MAX_SPEED, +MAX_SPEED]
- INIT_X, 300 / INIT_Y, 40: serve position, px
- INIT_Y_SPEED, 64: launch Y speed per level step, speed units (+ is down)
- LOST_Y, 470: integer Y above which the ball is lost

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- pause  in  1  freeze all state except resetLevel handling
- resetLevel  in  1  return to serve state
- level  in  4  current level, unsigned
- launch  in  1  one-cycle launch request
- collisionBorderTop / collisionBorderLeft / collisionBorderRight / collisionFlipper / collisionObstacle  in  1 each  collision flags
- hitEdgeCode  in  4  obstacle edge hit: [3]=left, [2]=top, [1]=right, [0]=bottom
- flipperSpeedX  in  SPEED_W  signed X kick on flipper hit
- topLeftX, topLeftY  out  11  signed integer position
- speedX, speedY  out  SPEED_W  signed current speeds
- state  out  2  0=ARMED, 1=FLIGHT, 2=LOST
- obstacleHit  out  1  one-cycle pulse, at most one per frame
- ballLost  out  1  one-cycle pulse on entering LOST

## Operation
- Position registers are signed, 12+FRAC_BITS bits. The integer output is position >>> FRAC_BITS (arithmetic shift, floor), truncated to 11 bits.
- Every speed write is sat(value): clamp to ±MAX_SPEED, with the sum computed at SPEED_W+1 bits before clamping.
- ARMED: position = (INIT_X, INIT_Y), speeds 0. On launch: go to FLIGHT with speedY = INIT_Y_SPEED*(level+1) and speedX = 0.
- FLIGHT, Y axis, while yLatch=0. First match wins:
  1. collisionBorderTop & speedY<0, or collisionFlipper & speedY>0: reflect, set yLatch.
  2. collisionObstacle & ((hitEdgeCode[2] & speedY<0) | (hitEdgeCode[0] & speedY>0)): reflect, set yLatch, raise obstacle event.
- FLIGHT, X axis, while xLatch=0. First match wins:
  1. collisionBorderLeft & speedX<0, or collisionBorderRight & speedX>0: reflect.
  2. collisionObstacle & ((hitEdgeCode[3] & speedX<0) | (hitEdgeCode[1] & speedX>0)): reflect, obstacle event.
  3. collisionFlipper & speedY>0: speedX = sat(speedX + flipperSpeedX).
  - Any match sets xLatch.
- Reflect means negate; the result is saturated, so -(-MAX_SPEED-1) cannot occur.
- startOfFrame in FLIGHT:
  - pos += current (pre-reflection) speed.
  - speedY = sat(reflected-or-held speedY + GRAVITY).
  - Clear xLatch, yLatch and the frame obstacle flag.
  - If the new integer Y > LOST_Y: go to LOST and pulse ballLost.
- Same-cycle collision and startOfFrame: both apply, per the rule above.
- LOST: position and speed frozen. launch goes to ARMED; launch in ARMED serves the ball.
- obstacleHit is registered: it is high the cycle after the first obstacle event of a frame, then low. Further events that frame give no pulse.
- pause=1: no state, position, speed or latch change; pending events are dropped. Pulses clear.
- resetLevel (ignores pause): from any state, go to ARMED with serve values; clear latches and pulses.

## Timing
- reset: state=ARMED, topLeftX=INIT_X, topLeftY=INIT_Y, speeds 0, obstacleHit=0, ballLost=0, latches 0. reset has priority over resetLevel.
- Position and speed outputs are registered. The position update is visible the cycle after startOfFrame.
- Collision-to-speed-reflection latency: 1 cycle.
- ballLost asserts the cycle after the startOfFrame that crossed LOST_Y.
- A launch pulse coinciding with startOfFrame in ARMED launches; no integration happens in that frame.

## Test plan
- Reset, then launch with level=1 → speedY=128, state=FLIGHT. After 1 frame: topLeftY=42, speedY=130. After 2 frames: topLeftY=44.
- speedY=510, GRAVITY=2, over 3 frames → speedY 512, 512, 512; never exceeds MAX_SPEED.
- speedY=-100, collisionBorderTop held for 3 cycles within one frame → speedY=+100 after 1 cycle, no further flips; +102 after the next startOfFrame.
- collisionObstacle with hitEdgeCode=4'b0001, speedY=+80, asserted twice in one frame → one reflection, obstacleHit high for exactly 1 cycle. The same stimulus in the next frame (now speedY<0) → no reflection, no pulse.
- Ball falls past Y=470 → ballLost 1-cycle pulse, state=LOST, position frozen across 5 frames. Then launch → ARMED at (300,40); second launch → FLIGHT.
- resetLevel asserted mid-flight with pause=1 → next cycle ARMED, (300,40), speeds 0. reset during FLIGHT → identical values.
